spectrum_bar_builder: RTL and testbench



---
 rtl/spectrum_bar_builder_if.sv | 21 ++
 rtl/spectrum_bar_builder.sv | 135 +++++++++++++
 tb/tb_spectrum_bar_builder.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_bar_builder_if.sv
// Bin stream handshake between the FFT magnitude source and the bar builder.
interface spectrum_bar_builder_if;
  logic        bin_valid;
  logic        bin_ready;
  logic [23:0] bin_mag;
  logic        bin_last;

  modport master (
    output bin_valid,
    output bin_mag,
    output bin_last,
    input  bin_ready
  );

  modport slave (
    input  bin_valid,
    input  bin_mag,
    input  bin_last,
    output bin_ready
  );
endinterface

// File: rtl/spectrum_bar_builder.sv
// Reduces a streamed FFT magnitude frame to 10 band peaks, applies peak-hold with
// linear decay and publishes the held levels only on a frame tick.
module spectrum_bar_builder #(
  parameter int unsigned BINS_PER_BAND = 16,
  parameter logic [23:0] DECAY         = 24'h004000,
  parameter logic [23:0] LEVEL_MAX     = 24'h77C000
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  spectrum_bar_builder_if.slave  bin,
  input  logic                   frame_tick,
  output logic [23:0]            x0,
  output logic [23:0]            x1,
  output logic [23:0]            x2,
  output logic [23:0]            x3,
  output logic [23:0]            x4,
  output logic [23:0]            x5,
  output logic [23:0]            x6,
  output logic [23:0]            x7,
  output logic [23:0]            x8,
  output logic [23:0]            x9,
  output logic                   frame_drop
);

  localparam int unsigned NumBands = 10;
  localparam int unsigned SubW     = (BINS_PER_BAND > 1) ? $clog2(BINS_PER_BAND) : 1;
  localparam logic [SubW-1:0] SubLast = SubW'(BINS_PER_BAND - 1);

  typedef enum logic [1:0] {StAccum, StHold, StCommit} state_e;

  state_e      state_q;
  logic        ready_q;
  logic        drop_q;
  logic [23:0] x_q   [NumBands];
  logic [23:0] acc_q [NumBands];
  // Bin index split into band and bin-within-band; band_q == NumBands means saturated.
  logic [3:0]      band_q;
  logic [SubW-1:0] sub_q;

  logic xfer;
  logic in_range;

  assign xfer     = bin.bin_valid & ready_q;
  assign in_range = band_q < 4'(NumBands);

  function automatic logic [23:0] sat_dec(input logic [23:0] a);
    return (a < DECAY) ? 24'd0 : (a - DECAY);
  endfunction

  function automatic logic [23:0] commit_level(input logic [23:0] acc, input logic [23:0] x);
    logic [23:0] d;
    logic [23:0] m;
    d = sat_dec(x);
    m = (acc > d) ? acc : d;
    return (m > LEVEL_MAX) ? LEVEL_MAX : m;
  endfunction

  // Frame FSM: accumulate band peaks, hold for the tick, then commit all bands at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StAccum;
      ready_q <= 1'b1;
      drop_q  <= 1'b0;
      band_q  <= 4'd0;
      sub_q   <= '0;
      for (int k = 0; k < NumBands; k++) begin
        x_q[k]   <= 24'd0;
        acc_q[k] <= 24'd0;
      end
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        StAccum: begin
          if (xfer && in_range) begin
            for (int k = 0; k < NumBands; k++) begin
              if ((band_q == 4'(k)) && (bin.bin_mag > acc_q[k])) begin
                acc_q[k] <= bin.bin_mag;
              end
            end
            if (sub_q == SubLast) begin
              sub_q  <= '0;
              band_q <= band_q + 4'd1;
            end else begin
              sub_q <= sub_q + SubW'(1);
            end
          end
          if (xfer && bin.bin_last) begin
            // A coincident tick skips HOLD; decay is folded into the commit.
            ready_q <= 1'b0;
            state_q <= frame_tick ? StCommit : StHold;
          end else if (frame_tick) begin
            // Tick before a full frame: decay only, keep accumulating.
            for (int k = 0; k < NumBands; k++) begin
              x_q[k] <= sat_dec(x_q[k]);
            end
            drop_q <= 1'b1;
          end
        end
        StHold: begin
          if (frame_tick) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          for (int k = 0; k < NumBands; k++) begin
            x_q[k]   <= commit_level(acc_q[k], x_q[k]);
            acc_q[k] <= 24'd0;
          end
          band_q  <= 4'd0;
          sub_q   <= '0;
          ready_q <= 1'b1;
          state_q <= StAccum;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StAccum;
        end
      endcase
    end
  end

  assign bin.bin_ready = ready_q;
  assign frame_drop    = drop_q;
  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];
  assign x4 = x_q[4];
  assign x5 = x_q[5];
  assign x6 = x_q[6];
  assign x7 = x_q[7];
  assign x8 = x_q[8];
  assign x9 = x_q[9];

endmodule

// File: tb/tb_spectrum_bar_builder.sv
// Directed bench for spectrum_bar_builder: frame commit, decay, saturation, drop,
// coincident last+tick, overlong frames and asynchronous reset.
module tb_spectrum_bar_builder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        frame_drop;
  logic [23:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9;
  logic [23:0] xv [10];
  logic [23:0] exp_x [10];
  logic [23:0] band_val [10];
  int          num_cmp = 0;
  int          num_err = 0;

  spectrum_bar_builder_if bif ();

  spectrum_bar_builder dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .bin        (bif.slave),
    .frame_tick (frame_tick),
    .x0         (x0),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .x4         (x4),
    .x5         (x5),
    .x6         (x6),
    .x7         (x7),
    .x8         (x8),
    .x9         (x9),
    .frame_drop (frame_drop)
  );

  always #5 Clk = ~Clk;

  assign xv[0] = x0;
  assign xv[1] = x1;
  assign xv[2] = x2;
  assign xv[3] = x3;
  assign xv[4] = x4;
  assign xv[5] = x5;
  assign xv[6] = x6;
  assign xv[7] = x7;
  assign xv[8] = x8;
  assign xv[9] = x9;

  // All stimulus tasks start and end on a falling edge.
  task automatic send_bin(input logic [23:0] m, input logic l, input logic t);
    int n = 0;
    while (bif.bin_ready !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (bif.bin_ready !== 1'b1) begin
      num_cmp++;
      num_err++;
      $display("FAIL ready_timeout: bin_ready=%b required 1", bif.bin_ready);
    end
    bif.bin_valid = 1'b1;
    bif.bin_mag   = m;
    bif.bin_last  = l;
    frame_tick    = t;
    @(negedge Clk);
    bif.bin_valid = 1'b0;
    bif.bin_mag   = 24'd0;
    bif.bin_last  = 1'b0;
    frame_tick    = 1'b0;
  endtask

  task automatic send_band_frame();
    for (int i = 0; i < 160; i++) send_bin(band_val[i / 16], (i == 159), 1'b0);
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_commit();
    do_tick();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    bif.bin_valid = 1'b0;
    bif.bin_mag   = 24'd0;
    bif.bin_last  = 1'b0;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 10; k++) begin
      num_cmp++;
      if (xv[k] !== 24'd0) begin
        num_err++;
        $display("FAIL reset_x%0d: got %h required 000000", k, xv[k]);
      end
    end
    num_cmp++;
    if (bif.bin_ready !== 1'b1) begin
      num_err++;
      $display("FAIL reset_ready: got %b required 1", bif.bin_ready);
    end
    num_cmp++;
    if (frame_drop !== 1'b0) begin
      num_err++;
      $display("FAIL reset_drop: got %b required 0", frame_drop);
    end
  endtask

  task automatic test_frame();
    for (int k = 0; k < 10; k++) band_val[k] = 24'((k + 1) * 32'h10000);
    send_band_frame();
    num_cmp++;
    if (bif.bin_ready !== 1'b0) begin
      num_err++;
      $display("FAIL frame_hold_ready: got %b required 0", bif.bin_ready);
    end
    do_tick();
    num_cmp++;
    if (bif.bin_ready !== 1'b0) begin
      num_err++;
      $display("FAIL frame_commit_ready: got %b required 0", bif.bin_ready);
    end
    num_cmp++;
    if (x0 !== 24'd0) begin
      num_err++;
      $display("FAIL frame_latency_x0: got %h required 000000", x0);
    end
    @(negedge Clk);
    for (int k = 0; k < 10; k++) begin
      num_cmp++;
      if (xv[k] !== band_val[k]) begin
        num_err++;
        $display("FAIL frame_x%0d: got %h required %h", k, xv[k], band_val[k]);
      end
    end
    num_cmp++;
    if (bif.bin_ready !== 1'b1) begin
      num_err++;
      $display("FAIL frame_ready_after: got %b required 1", bif.bin_ready);
    end
  endtask

  task automatic test_decay();
    for (int k = 0; k < 10; k++) band_val[k] = 24'd0;
    band_val[0] = 24'h100000;
    send_band_frame();
    do_commit();
    num_cmp++;
    if (x0 !== 24'h100000) begin
      num_err++;
      $display("FAIL decay_set_x0: got %h required 100000", x0);
    end
    num_cmp++;
    if (x1 !== 24'h01C000) begin
      num_err++;
      $display("FAIL decay_set_x1: got %h required 01C000", x1);
    end
    send_bin(24'd0, 1'b1, 1'b0);
    do_commit();
    num_cmp++;
    if (x0 !== 24'h0FC000) begin
      num_err++;
      $display("FAIL decay_one_x0: got %h required 0FC000", x0);
    end
    for (int f = 0; f < 62; f++) begin
      send_bin(24'd0, 1'b1, 1'b0);
      do_commit();
    end
    num_cmp++;
    if (x0 !== 24'h004000) begin
      num_err++;
      $display("FAIL decay_62_x0: got %h required 004000", x0);
    end
    for (int f = 0; f < 2; f++) begin
      send_bin(24'd0, 1'b1, 1'b0);
      do_commit();
    end
    for (int k = 0; k < 10; k++) begin
      num_cmp++;
      if (xv[k] !== 24'd0) begin
        num_err++;
        $display("FAIL decay_floor_x%0d: got %h required 000000", k, xv[k]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 10; k++) band_val[k] = 24'd0;
    band_val[9] = 24'hFFFFFF;
    send_band_frame();
    do_commit();
    num_cmp++;
    if (x9 !== 24'h77C000) begin
      num_err++;
      $display("FAIL sat_x9: got %h required 77C000", x9);
    end
    num_cmp++;
    if (x8 !== 24'd0) begin
      num_err++;
      $display("FAIL sat_x8: got %h required 000000", x8);
    end
    send_bin(24'd0, 1'b1, 1'b0);
    do_commit();
    num_cmp++;
    if (x9 !== 24'h778000) begin
      num_err++;
      $display("FAIL sat_decay_x9: got %h required 778000", x9);
    end
  endtask

  task automatic test_drop();
    for (int k = 0; k < 10; k++) band_val[k] = 24'd0;
    band_val[3] = 24'h008000;
    send_band_frame();
    do_commit();
    num_cmp++;
    if (x3 !== 24'h008000) begin
      num_err++;
      $display("FAIL drop_set_x3: got %h required 008000", x3);
    end
    for (int i = 0; i < 40; i++) send_bin(24'h060000, 1'b0, 1'b0);
    do_tick();
    num_cmp++;
    if (frame_drop !== 1'b1) begin
      num_err++;
      $display("FAIL drop_pulse: got %b required 1", frame_drop);
    end
    num_cmp++;
    if (x3 !== 24'h004000) begin
      num_err++;
      $display("FAIL drop_decay_x3: got %h required 004000", x3);
    end
    num_cmp++;
    if (x9 !== 24'h770000) begin
      num_err++;
      $display("FAIL drop_decay_x9: got %h required 770000", x9);
    end
    num_cmp++;
    if (bif.bin_ready !== 1'b1) begin
      num_err++;
      $display("FAIL drop_ready: got %b required 1", bif.bin_ready);
    end
    @(negedge Clk);
    num_cmp++;
    if (frame_drop !== 1'b0) begin
      num_err++;
      $display("FAIL drop_single: got %b required 0", frame_drop);
    end
    for (int i = 0; i < 120; i++) send_bin(24'h010000, (i == 119), 1'b0);
    do_commit();
    exp_x[0] = 24'h060000;
    exp_x[1] = 24'h060000;
    exp_x[2] = 24'h060000;
    for (int k = 3; k < 9; k++) exp_x[k] = 24'h010000;
    exp_x[9] = 24'h76C000;
    for (int k = 0; k < 10; k++) begin
      num_cmp++;
      if (xv[k] !== exp_x[k]) begin
        num_err++;
        $display("FAIL drop_commit_x%0d: got %h required %h", k, xv[k], exp_x[k]);
      end
    end
  endtask

  task automatic test_simul();
    send_bin(24'h200000, 1'b1, 1'b1);
    num_cmp++;
    if (bif.bin_ready !== 1'b0) begin
      num_err++;
      $display("FAIL simul_commit_ready: got %b required 0", bif.bin_ready);
    end
    num_cmp++;
    if (frame_drop !== 1'b0) begin
      num_err++;
      $display("FAIL simul_drop: got %b required 0", frame_drop);
    end
    // Tick during COMMIT must be ignored.
    do_tick();
    exp_x[0] = 24'h200000;
    exp_x[1] = 24'h05C000;
    exp_x[2] = 24'h05C000;
    for (int k = 3; k < 9; k++) exp_x[k] = 24'h00C000;
    exp_x[9] = 24'h768000;
    for (int k = 0; k < 10; k++) begin
      num_cmp++;
      if (xv[k] !== exp_x[k]) begin
        num_err++;
        $display("FAIL simul_x%0d: got %h required %h", k, xv[k], exp_x[k]);
      end
    end
    @(negedge Clk);
    num_cmp++;
    if (frame_drop !== 1'b0) begin
      num_err++;
      $display("FAIL simul_commit_tick_drop: got %b required 0", frame_drop);
    end
    num_cmp++;
    if (x0 !== 24'h200000) begin
      num_err++;
      $display("FAIL simul_commit_tick_x0: got %h required 200000", x0);
    end
  endtask

  task automatic test_overlong();
    for (int i = 0; i < 200; i++) begin
      send_bin((i < 160) ? 24'd0 : 24'hFFFFFF, (i == 199), 1'b0);
    end
    do_commit();
    exp_x[0] = 24'h1FC000;
    exp_x[1] = 24'h058000;
    exp_x[2] = 24'h058000;
    for (int k = 3; k < 9; k++) exp_x[k] = 24'h008000;
    exp_x[9] = 24'h764000;
    for (int k = 0; k < 10; k++) begin
      num_cmp++;
      if (xv[k] !== exp_x[k]) begin
        num_err++;
        $display("FAIL overlong_x%0d: got %h required %h", k, xv[k], exp_x[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 50; i++) send_bin(24'h300000, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      num_cmp++;
      if (xv[k] !== 24'd0) begin
        num_err++;
        $display("FAIL areset_x%0d: got %h required 000000", k, xv[k]);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    num_cmp++;
    if (bif.bin_ready !== 1'b1) begin
      num_err++;
      $display("FAIL areset_ready: got %b required 1", bif.bin_ready);
    end
    send_bin(24'd0, 1'b1, 1'b0);
    do_commit();
    for (int k = 0; k < 10; k++) begin
      num_cmp++;
      if (xv[k] !== 24'd0) begin
        num_err++;
        $display("FAIL areset_discard_x%0d: got %h required 000000", k, xv[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_decay();
    test_saturation();
    test_drop();
    test_simul();
    test_overlong();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule
